// File: rtl/canvas_reader.sv
// Streams the 1-bpp canvas out in raster order as MSB-first bytes, with optional clear-after-read (CANVAS_READER_CLEAR_EN).
// Latency: 8 reads plus 1 drain cycle per byte; out_valid holds its data until out_ready, and no reads are issued during a stall.
module canvas_reader #(
  parameter int PANEL_WIDTH  = 256,
  parameter int PANEL_HEIGHT = 192,
  parameter int ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_x,
  output logic [ADDR_W-1:0] rd_y,
  input  logic              rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_x,
  output logic [ADDR_W-1:0] wr_y,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, PRESENT} state_e;

  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(PANEL_WIDTH - 1);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(PANEL_HEIGHT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] x_q, x_d, y_q, y_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic [2:0]        rd_pos_q, rd_pos_d;
  logic [7:0]        byte_q, byte_d;
  logic              done_q, done_d;
  logic              eol, eof;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    rd_vld_d  = 1'b0;
    rd_pos_d  = cnt_q;
    byte_d    = byte_q;
    done_d    = 1'b0;
    rd_en     = 1'b0;
    out_valid = 1'b0;
    eol       = (x_q == X_LAST);
    eof       = eol && (y_q == Y_LAST);

    // Each bit lands at the position it was read for, so short row-end bytes stay left-aligned.
    if (rd_vld_q) byte_d[3'd7 - rd_pos_q] = rd_data;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
          byte_d  = '0;
        end
      end
      FETCH: begin
        rd_en    = 1'b1;
        rd_vld_d = 1'b1;
        if (cnt_q == 3'd7 || eol) begin
          state_d = DRAIN;
        end else begin
          x_d   = x_q + ADDR_W'(1);
          cnt_d = cnt_q + 3'd1;
        end
      end
      DRAIN: state_d = PRESENT;
      PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d  = '0;
          byte_d = '0;
          if (eof) begin
            state_d = IDLE;
            done_d  = 1'b1;
            x_d     = '0;
            y_d     = '0;
          end else begin
            state_d = FETCH;
            if (eol) begin
              x_d = '0;
              y_d = y_q + ADDR_W'(1);
            end else begin
              x_d = x_q + ADDR_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d  = IDLE;
      rd_vld_d = 1'b0;
      done_d   = 1'b0;
      x_d      = '0;
      y_d      = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_pos_q <= '0;
      byte_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      rd_vld_q <= rd_vld_d;
      rd_pos_q <= rd_pos_d;
      byte_q   <= byte_d;
      done_q   <= done_d;
    end
  end

  assign rd_x     = x_q;
  assign rd_y     = y_q;
  assign out_data = byte_q;
  assign out_eol  = out_valid && eol;
  assign out_eof  = out_valid && eof;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

`ifdef CANVAS_READER_CLEAR_EN
  // Coordinates follow the read by one cycle so the clear lines up with the data capture.
  logic [ADDR_W-1:0] cap_x_q, cap_x_d, cap_y_q, cap_y_d;

  always_comb begin
    cap_x_d = rd_en ? x_q : cap_x_q;
    cap_y_d = rd_en ? y_q : cap_y_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_x_q <= '0;
      cap_y_q <= '0;
    end else begin
      cap_x_q <= cap_x_d;
      cap_y_q <= cap_y_d;
    end
  end

  assign wr_en = rd_vld_q;
  assign wr_x  = cap_x_q;
  assign wr_y  = cap_y_q;
`else
  assign wr_en = 1'b0;
  assign wr_x  = '0;
  assign wr_y  = '0;
`endif

endmodule

// File: tb/tb_canvas_reader.sv
// Directed bench for canvas_reader: a 16x2 instance and a 10x2 instance against a canvas memory model and an expected-byte queue.
module tb_canvas_reader;

  localparam int AW = 12;

  typedef struct packed {
    logic [7:0] d;
    logic       eol;
    logic       eof;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    start, abort, rd_en, rd_data, wr_en, out_valid, out_ready, out_eol, out_eof, busy, done;
  logic [AW-1:0] rd_x [2];
  logic [AW-1:0] rd_y [2];
  logic [AW-1:0] wr_x [2];
  logic [AW-1:0] wr_y [2];
  logic [7:0]    out_data [2];

  logic mem [2][2][16];
  logic img [2][2][16];
  logic load = 1'b0;
  int   wr_cnt [2] = '{0, 0};
  int   done_cnt [2] = '{0, 0};
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  canvas_reader #(.PANEL_WIDTH(16), .PANEL_HEIGHT(2), .ADDR_W(AW)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .rd_en(rd_en[0]), .rd_x(rd_x[0]), .rd_y(rd_y[0]), .rd_data(rd_data[0]),
    .wr_en(wr_en[0]), .wr_x(wr_x[0]), .wr_y(wr_y[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_eol(out_eol[0]), .out_eof(out_eof[0]), .busy(busy[0]), .done(done[0])
  );

  canvas_reader #(.PANEL_WIDTH(10), .PANEL_HEIGHT(2), .ADDR_W(AW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .rd_en(rd_en[1]), .rd_x(rd_x[1]), .rd_y(rd_y[1]), .rd_data(rd_data[1]),
    .wr_en(wr_en[1]), .wr_x(wr_x[1]), .wr_y(wr_y[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_eol(out_eol[1]), .out_eof(out_eof[1]), .busy(busy[1]), .done(done[1])
  );

  // Canvas memory: registered read, clear writes, bulk load from the bench image.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rd_en[d]) rd_data[d] <= mem[d][rd_y[d][0]][rd_x[d][3:0]];
      if (wr_en[d]) wr_cnt[d] <= wr_cnt[d] + 1;
      if (done[d])  done_cnt[d] <= done_cnt[d] + 1;
    end
    if (load) begin
      mem <= img;
    end else begin
      for (int d = 0; d < 2; d++)
        if (wr_en[d]) mem[d][wr_y[d][0]][wr_x[d][3:0]] <= 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_img;
    for (int d = 0; d < 2; d++)
      for (int y = 0; y < 2; y++)
        for (int x = 0; x < 16; x++) img[d][y][x] = 1'b0;
  endtask

  task automatic load_img;
    load = 1'b1;
    tick;
    load = 1'b0;
  endtask

  task automatic push(input logic [7:0] dat, input logic eol, input logic eof);
    exp_t e;
    e.d = dat; e.eol = eol; e.eof = eof;
    sb.push_back(e);
  endtask

  task automatic start_pulse(input int d);
    int lat;
    start[d] = 1'b1;
    tick;
    start[d] = 1'b0;
    check("busy_after_start", busy[d], 1);
    lat = 1;
    while (!out_valid[d] && lat < 50) begin tick; lat++; end
    check("first_valid_latency", lat, 10);
  endtask

  task automatic collect(input int d, input int n, input int stall_at, input bit chk_done);
    exp_t e;
    int   w, bad, rds;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!out_valid[d] && w < 40) begin tick; w++; end
      check("valid_wait", out_valid[d], 1);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      check("out_data", out_data[d], e.d);
      check("out_eol", out_eol[d], e.eol);
      check("out_eof", out_eof[d], e.eof);
      check("done_idle", done[d], 0);
      if (i == stall_at) begin
        out_ready[d] = 1'b0;
        bad = 0;
        rds = 0;
        repeat (20) begin
          tick;
          if (out_valid[d] !== 1'b1 || out_data[d] !== e.d || out_eol[d] !== e.eol) bad++;
          if (rd_en[d] !== 1'b0) rds++;
        end
        check("stall_stable", bad, 0);
        check("stall_no_rd", rds, 0);
        out_ready[d] = 1'b1;
      end
      tick;
    end
    if (chk_done) begin
      check("done_pulse", done[d], 1);
      check("busy_at_done", busy[d], 0);
      check("valid_at_done", out_valid[d], 0);
      tick;
      check("done_one_cycle", done[d], 0);
    end
  endtask

  initial begin
    int base, vcnt;
    start = '0; abort = '0; out_ready = 2'b11;
    clear_img;
    load_img;
    tick;
    rst_n = 1'b1;
    tick;
    check("rst_busy", busy, 2'b00);
    check("rst_valid", out_valid, 2'b00);
    check("rst_rd_en", rd_en, 2'b00);
    check("rst_done", done, 2'b00);
    check("rst_eol_eof", {out_eol, out_eof}, 4'b0);
    check("rst_wr_en", wr_en, 2'b00);
    check("rst_rd_x", rd_x[0], 0);

    // Blank canvas.
    push(8'h00, 0, 0); push(8'h00, 1, 0); push(8'h00, 0, 0); push(8'h00, 1, 1);
    start_pulse(0);
    collect(0, 4, -1, 1);

    // Three black pixels, with a 20-cycle stall on byte 1.
    clear_img;
    img[0][0][0] = 1'b1; img[0][0][7] = 1'b1; img[0][1][9] = 1'b1;
    load_img;
    push(8'h81, 0, 0); push(8'h00, 1, 0); push(8'h00, 0, 0); push(8'h40, 1, 1);
    start_pulse(0);
    collect(0, 4, 1, 1);

    // Start and abort together in IDLE: abort wins.
    start[0] = 1'b1; abort[0] = 1'b1;
    tick;
    start[0] = 1'b0; abort[0] = 1'b0;
    check("start_abort_busy", busy[0], 0);
    tick;
    check("start_abort_rd_en", rd_en[0], 0);

    // Abort during the second fetch, then a clean restart.
    clear_img;
    img[0][0][3] = 1'b1; img[0][1][15] = 1'b1;
    load_img;
    push(8'h10, 0, 0); push(8'h00, 1, 0); push(8'h00, 0, 0); push(8'h01, 1, 1);
    start_pulse(0);
    collect(0, 1, -1, 0);
    check("second_fetch_rd_en", rd_en[0], 1);
    base = done_cnt[0];
    abort[0] = 1'b1;
    tick;
    abort[0] = 1'b0;
    check("abort_busy", busy[0], 0);
    check("abort_valid", out_valid[0], 0);
    check("abort_rd_en", rd_en[0], 0);
    vcnt = 0;
    repeat (15) begin tick; if (out_valid[0] !== 1'b0) vcnt++; end
    check("abort_quiet", vcnt, 0);
    check("abort_no_done", done_cnt[0] - base, 0);
    sb.delete();
    load_img;
    push(8'h10, 0, 0); push(8'h00, 1, 0); push(8'h00, 0, 0); push(8'h01, 1, 1);
    start_pulse(0);
    collect(0, 4, -1, 1);

    // Width 10: row-end byte padded in the LSBs.
    clear_img;
    img[1][0][9] = 1'b1;
    load_img;
    push(8'h00, 0, 0); push(8'h40, 1, 0); push(8'h00, 0, 0); push(8'h00, 1, 1);
    start_pulse(1);
    collect(1, 4, -1, 1);

    // Asynchronous reset in the middle of a frame.
    start[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    repeat (4) tick;
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy[0], 0);
    check("arst_rd_en", rd_en[0], 0);
    check("arst_valid", out_valid[0], 0);
    tick;
    rst_n = 1'b1;
    vcnt = 0;
    repeat (15) begin tick; if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) vcnt++; end
    check("arst_no_partial", vcnt, 0);

    // Five pixels, read twice: with clear-after-read the second pass is blank.
    clear_img;
    img[0][0][0] = 1'b1; img[0][0][15] = 1'b1;
    img[0][1][1] = 1'b1; img[0][1][2] = 1'b1; img[0][1][8] = 1'b1;
    load_img;
    base = wr_cnt[0];
    push(8'h80, 0, 0); push(8'h01, 1, 0); push(8'h60, 0, 0); push(8'h80, 1, 1);
    start_pulse(0);
    collect(0, 4, -1, 1);
`ifdef CANVAS_READER_CLEAR_EN
    check("wr_pulses", wr_cnt[0] - base, 32);
    push(8'h00, 0, 0); push(8'h00, 1, 0); push(8'h00, 0, 0); push(8'h00, 1, 1);
`else
    check("wr_pulses", wr_cnt[0] - base, 0);
    push(8'h80, 0, 0); push(8'h01, 1, 0); push(8'h60, 0, 0); push(8'h80, 1, 1);
`endif
    start_pulse(0);
    collect(0, 4, -1, 1);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
